// File: rtl/instr_sequencer.sv
// Instruction sequencer: walks a datapath through a held reset and then a
// stepped instruction index, optionally looping, and counts completed passes.
module instr_sequencer #(
  parameter int IDX_W        = 2,
  parameter int NUM_STEPS    = 4,
  parameter int RESET_CYCLES = 1,
  parameter int HOLD_CYCLES  = 1,
  parameter int LOOP         = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  output logic [IDX_W-1:0] i,
  output logic             dp_reset,
  output logic             busy,
  output logic             done,
  output logic [7:0]       pass_count,
  output logic [1:0]       dbg_state
);

  if (IDX_W < 1) begin : g_bad_idx_w
    $error("instr_sequencer: IDX_W must be >= 1");
  end
  if (NUM_STEPS < 1 || NUM_STEPS > (1 << IDX_W)) begin : g_bad_num_steps
    $error("instr_sequencer: NUM_STEPS must be in 1..2**IDX_W");
  end
  if (RESET_CYCLES < 1) begin : g_bad_reset_cycles
    $error("instr_sequencer: RESET_CYCLES must be >= 1");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold_cycles
    $error("instr_sequencer: HOLD_CYCLES must be >= 1");
  end
  if (LOOP != 0 && LOOP != 1) begin : g_bad_loop
    $error("instr_sequencer: LOOP must be 0 or 1");
  end

  localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [RC_W-1:0]  RC_LAST = RC_W'(RESET_CYCLES - 1);
  localparam logic [HC_W-1:0]  HC_LAST = HC_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] I_LAST  = IDX_W'(NUM_STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_RESET_HOLD = 2'd1,
    S_RUN        = 2'd2,
    S_DONE       = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] i_q, i_d;
  logic [RC_W-1:0]  rcnt_q, rcnt_d;
  logic [HC_W-1:0]  hcnt_q, hcnt_d;
  logic [7:0]       pass_q, pass_d;
  logic             dp_reset_q, dp_reset_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Control priority: reset (in the register block) > abort > start/pause.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    rcnt_d  = rcnt_q;
    hcnt_d  = hcnt_q;
    pass_d  = pass_q;
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      i_d     = '0;
      rcnt_d  = '0;
      hcnt_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_RESET_HOLD;
            rcnt_d  = '0;
          end
        end
        S_RESET_HOLD: begin
          if (rcnt_q == RC_LAST) begin
            state_d = S_RUN;
            i_d     = '0;
            hcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + RC_W'(1);
          end
        end
        S_RUN: begin
          if (!pause) begin
            if (hcnt_q == HC_LAST) begin
              hcnt_d = '0;
              // Last step ends the pass explicitly so a full-range index never overflows.
              if (i_q == I_LAST) begin
                if (pass_q != 8'hFF) pass_d = pass_q + 8'd1;
                if (LOOP != 0) i_d = '0;
                else           state_d = S_DONE;
              end else begin
                i_d = i_q + IDX_W'(1);
              end
            end else begin
              hcnt_d = hcnt_q + HC_W'(1);
            end
          end
        end
        S_DONE: begin
          if (start) begin
            state_d = S_RESET_HOLD;
            i_d     = '0;
            rcnt_d  = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    dp_reset_d = (state_d == S_IDLE) || (state_d == S_RESET_HOLD);
    busy_d     = (state_d == S_RESET_HOLD) || (state_d == S_RUN);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      i_q        <= '0;
      rcnt_q     <= '0;
      hcnt_q     <= '0;
      pass_q     <= '0;
      dp_reset_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      rcnt_q     <= rcnt_d;
      hcnt_q     <= hcnt_d;
      pass_q     <= pass_d;
      dp_reset_q <= dp_reset_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign i          = i_q;
  assign dp_reset   = dp_reset_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass_count = pass_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: four parameterisations share one stimulus stream;
// a cycle-level reference model feeds an expected queue checked by a monitor.
module tb_instr_sequencer;

  logic clk;
  logic reset, start, pause, abort;

  logic [1:0] i0, i1, i2;
  logic [2:0] i3;
  logic [3:0] dp_w, busy_w, done_w;
  logic [7:0] pc_w [4];
  logic [1:0] dbg_w [4];
  logic [13:0] got_v [4];

  instr_sequencer u_def (
    .clock(clk), .reset(reset), .start(start), .pause(pause), .abort(abort),
    .i(i0), .dp_reset(dp_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .pass_count(pc_w[0]), .dbg_state(dbg_w[0]));

  instr_sequencer #(.RESET_CYCLES(3), .HOLD_CYCLES(2)) u_hold (
    .clock(clk), .reset(reset), .start(start), .pause(pause), .abort(abort),
    .i(i1), .dp_reset(dp_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .pass_count(pc_w[1]), .dbg_state(dbg_w[1]));

  instr_sequencer #(.LOOP(1)) u_loop (
    .clock(clk), .reset(reset), .start(start), .pause(pause), .abort(abort),
    .i(i2), .dp_reset(dp_w[2]), .busy(busy_w[2]), .done(done_w[2]),
    .pass_count(pc_w[2]), .dbg_state(dbg_w[2]));

  instr_sequencer #(.IDX_W(3), .NUM_STEPS(5), .RESET_CYCLES(2), .HOLD_CYCLES(3), .LOOP(1)) u_odd (
    .clock(clk), .reset(reset), .start(start), .pause(pause), .abort(abort),
    .i(i3), .dp_reset(dp_w[3]), .busy(busy_w[3]), .done(done_w[3]),
    .pass_count(pc_w[3]), .dbg_state(dbg_w[3]));

  assign got_v[0] = {1'b0, i0, dp_w[0], busy_w[0], done_w[0], pc_w[0]};
  assign got_v[1] = {1'b0, i1, dp_w[1], busy_w[1], done_w[1], pc_w[1]};
  assign got_v[2] = {1'b0, i2, dp_w[2], busy_w[2], done_w[2], pc_w[2]};
  assign got_v[3] = {i3, dp_w[3], busy_w[3], done_w[3], pc_w[3]};

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per-instance parameters and abstract state.
  int ns [4] = '{4, 4, 4, 5};
  int rc [4] = '{1, 3, 1, 2};
  int hc [4] = '{1, 2, 1, 3};
  int lp [4] = '{0, 0, 1, 1};

  int mode      [4];  // 0 idle, 1 datapath reset held, 2 stepping, 3 finished
  int prep_left [4];
  int run_t     [4];  // unpaused stepping cycles since entering the run
  int base_pass [4];
  int passes    [4];

  logic [55:0] exp_q [$];
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  function automatic logic [13:0] expect_out(input int k);
    int idx;
    logic dp, bz, dn;
    idx = 0; dp = 1'b1; bz = 1'b0; dn = 1'b0;
    case (mode[k])
      1: begin idx = 0; dp = 1'b1; bz = 1'b1; end
      2: begin idx = (run_t[k] / hc[k]) % ns[k]; dp = 1'b0; bz = 1'b1; end
      3: begin idx = ns[k] - 1; dp = 1'b0; dn = 1'b1; end
      default: ;
    endcase
    return {3'(idx), dp, bz, dn, 8'(passes[k])};
  endfunction

  task automatic model_step(input int k, input logic r, input logic s,
                            input logic p, input logic a);
    int per, tot;
    per = hc[k] * ns[k];
    if (r) begin
      mode[k]   = 0;
      passes[k] = 0;
    end else if (a && mode[k] != 0) begin
      mode[k] = 0;
    end else begin
      case (mode[k])
        0, 3: if (s) begin mode[k] = 1; prep_left[k] = rc[k]; end
        1: begin
          prep_left[k] = prep_left[k] - 1;
          if (prep_left[k] == 0) begin
            mode[k] = 2; run_t[k] = 0; base_pass[k] = passes[k];
          end
        end
        2: if (!p) begin
          run_t[k] = run_t[k] + 1;
          tot = base_pass[k] + run_t[k] / per;
          passes[k] = (tot > 255) ? 255 : tot;
          if (lp[k] == 0 && run_t[k] == per) mode[k] = 3;
        end
        default: mode[k] = 0;
      endcase
    end
  endtask

  // Driver: apply one cycle of inputs and queue the response expected after the edge.
  task automatic step(input logic r, input logic s, input logic p, input logic a);
    logic [55:0] e;
    reset = r; start = s; pause = p; abort = a;
    for (int k = 0; k < 4; k++) begin
      model_step(k, r, s, p, a);
      e[k*14 +: 14] = expect_out(k);
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Scoreboard monitor
  initial begin
    logic [55:0] e;
    logic [13:0] x;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        for (int k = 0; k < 4; k++) begin
          x = e[k*14 +: 14];
          n_vec++;
          if (got_v[k] !== x) begin
            n_err++;
            $display("FAIL u%0d outputs cycle %0d: got i=%0d dp=%b busy=%b done=%b pc=%0d, expected i=%0d dp=%b busy=%b done=%b pc=%0d",
                     k, cyc, got_v[k][13:11], got_v[k][10], got_v[k][9], got_v[k][8], got_v[k][7:0],
                     x[13:11], x[10], x[9], x[8], x[7:0]);
          end
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < 4; k++) begin
      mode[k] = 0; prep_left[k] = 0; run_t[k] = 0; base_pass[k] = 0; passes[k] = 0;
    end
    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    // Single pass from a one-cycle start pulse
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(16);
    // Pause for three cycles while index is 1
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(16);
    // Reset mid-run, then start while busy
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(16);
    // Abort together with start and pause mid-run, then two full passes
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    idle(3);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(16);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(16);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    // Randomized control traffic
    for (int n = 0; n < 800; n++) begin
      step($urandom_range(0, 99) < 1,
           $urandom_range(0, 99) < 12,
           $urandom_range(0, 99) < 25,
           $urandom_range(0, 99) < 3);
    end
    // Long uninterrupted looping run to reach pass_count saturation
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(3900);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(20);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard drain: got %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
